// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 8N1, majority-of-three filtering,
// registered one-cycle data/error strobes.
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic       rxd_i,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rxd_s;
  logic [2:0]             samp_reg;
  logic [2:0]             samp_next;
  logic                   maj;
  state_t                 state_reg;
  logic [3:0]             tcnt_reg;
  logic [2:0]             bcnt_reg;
  logic [7:0]             shift_reg;

  // Line synchronizer; flops reset to the idle (high) level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], rxd_i};
    end
  end

  assign rxd_s = sync_reg[SYNC_STAGES-1];

  // The deciding tick votes with its own sample plus the two before it.
  assign samp_next = {samp_reg[1:0], rxd_s};
  assign maj = (samp_next[0] & samp_next[1]) |
               (samp_next[0] & samp_next[2]) |
               (samp_next[1] & samp_next[2]);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      tcnt_reg     <= 4'd0;
      bcnt_reg     <= 3'd0;
      samp_reg     <= 3'b111;
      shift_reg    <= 8'h00;
      data_o       <= 8'h00;
      data_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      data_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
      if (tick_i) begin
        samp_reg <= samp_next;
        case (state_reg)
          IDLE: begin
            if (!rxd_s) begin
              state_reg <= START;
              tcnt_reg  <= 4'd0;
              busy_o    <= 1'b1;
            end
          end
          START: begin
            tcnt_reg <= tcnt_reg + 4'd1;
            // Mid-point of the start bit: confirm it is still low.
            if (tcnt_reg == 4'd7) begin
              if (maj) begin
                state_reg <= IDLE;
                tcnt_reg  <= 4'd0;
                busy_o    <= 1'b0;
              end else begin
                state_reg <= DATA;
                tcnt_reg  <= 4'd0;
                bcnt_reg  <= 3'd0;
              end
            end
          end
          DATA: begin
            tcnt_reg <= tcnt_reg + 4'd1;
            if (tcnt_reg == 4'd15) begin
              shift_reg <= {maj, shift_reg[7:1]};
              bcnt_reg  <= bcnt_reg + 3'd1;
              if (bcnt_reg == 3'd7) begin
                state_reg <= STOP;
                tcnt_reg  <= 4'd0;
              end
            end
          end
          STOP: begin
            tcnt_reg <= tcnt_reg + 4'd1;
            if (tcnt_reg == 4'd15) begin
              tcnt_reg <= 4'd0;
              if (maj) begin
                data_o       <= shift_reg;
                data_valid_o <= 1'b1;
                state_reg    <= IDLE;
                busy_o       <= 1'b0;
              end else begin
                frame_err_o <= 1'b1;
                state_reg   <= WAIT_HIGH;
              end
            end
          end
          WAIT_HIGH: begin
            // Hold here through a break so it reports a single error.
            if (rxd_s) begin
              state_reg <= IDLE;
              busy_o    <= 1'b0;
            end
          end
          default: begin
            state_reg <= IDLE;
            tcnt_reg  <= 4'd0;
            bcnt_reg  <= 3'd0;
            busy_o    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
